centroid_tracker: RTL and testbench

//  Consumes the filtered RGB565 pixel stream from the filter stage and thresholds each pixel into a pen-tip mask.

---
 rtl/tracker_pkg.sv | 28 ++
 rtl/divider_serial.sv | 89 ++++++++
 rtl/centroid_tracker.sv | 268 ++++++++++++++++++++++++++
 tb/tb_centroid_tracker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared types and widths for the centroid tracker.
//   tracker_state_t : control FSM states
//   SUMX_W/SUMY_W   : moment accumulator widths (sized for 1024x768)
//   CNT_W           : masked-pixel counter width
//   DIV_W           : serial divider operand width
//   rgb565_t        : RGB565 pixel view
//   pixel_masked()  : colour threshold predicate
package tracker_pkg;

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} tracker_state_t;

    localparam int unsigned SUMX_W = 31;
    localparam int unsigned SUMY_W = 30;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned DIV_W  = 32;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic pixel_masked(input rgb565_t pix, input logic [4:0] r_min,
                                          input logic [5:0] g_max, input logic [4:0] b_max);
        return (pix.r >= r_min) && (pix.g <= g_max) && (pix.b <= b_max);
    endfunction

endpackage

// File: rtl/divider_serial.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first iteration runs on the start_in edge, so done_out pulses exactly WIDTH cycles
// after start_in. A zero divisor still runs the full sequence and returns quotient 0.
// Ports:
//   clk_in, rst_in (async, active-low)
//   start_in     : 1-cycle start pulse, samples dividend_in/divisor_in
//   dividend_in  : WIDTH-bit dividend
//   divisor_in   : WIDTH-bit divisor
//   quotient_out : truncated quotient, valid from done_out onwards
//   done_out     : 1-cycle completion pulse
module divider_serial
    import tracker_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic             done_out
);

    localparam int unsigned ITER_W = $clog2(WIDTH);

    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_quo;
    logic [WIDTH-1:0]  r_div;
    logic [ITER_W-1:0] r_iter;
    logic              r_busy;
    logic              r_zero;
    logic              r_done;

    logic [WIDTH-1:0]  w_rem_src;
    logic [WIDTH-1:0]  w_quo_src;
    logic [WIDTH-1:0]  w_div_src;
    logic [WIDTH:0]    w_rem_sh;
    logic [WIDTH:0]    w_diff;
    logic              w_fits;
    logic [WIDTH-1:0]  w_rem_nxt;
    logic [WIDTH-1:0]  w_quo_nxt;

    // On start, iterate directly on the fresh operands.
    always_comb begin
        w_rem_src = start_in ? '0 : r_rem;
        w_quo_src = start_in ? dividend_in : r_quo;
        w_div_src = start_in ? divisor_in : r_div;
        w_rem_sh  = {w_rem_src, w_quo_src[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, w_div_src};
        w_fits    = ~w_diff[WIDTH];
        w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo_nxt = {w_quo_src[WIDTH-2:0], w_fits};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_iter <= '0;
            r_busy <= 1'b0;
            r_zero <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_in) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_div  <= divisor_in;
                r_zero <= (divisor_in == '0);
                r_iter <= ITER_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_iter <= r_iter + 1'b1;
                if (r_iter == ITER_W'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient_out = r_zero ? '0 : r_quo;
    assign done_out     = r_done;

endmodule

// File: rtl/centroid_tracker.sv
// Pen-tip centroid tracker: thresholds an RGB565 stream into a mask, accumulates X/Y moments
// and a pixel count per frame, then divides serially at frame end and reports the centroid
// 34 cycles after the frame-end pixel. A 1-cycle-delayed mask stream feeds the debug overlay.
// Optional feature macro: CENTROID_BBOX_EN adds per-frame bounding-box outputs.
// Ports:
//   clk_in, rst_in (async, active-low)
//   data_valid_in, pixel_data_in, hcount_in, vcount_in : filtered pixel stream
//   r_min_in, g_max_in, b_max_in                        : mask thresholds
//   mask_valid_out, mask_out, hcount_out, vcount_out    : delayed mask stream
//   x_out, y_out, count_out, found_out, valid_out       : per-frame centroid report
//   frame_drop_out                                      : frame end seen while busy
//   bbox_*_out (CENTROID_BBOX_EN only)                  : masked-pixel bounding box
module centroid_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        data_valid_in,
    input  logic [15:0] pixel_data_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [4:0]  r_min_in,
    input  logic [5:0]  g_max_in,
    input  logic [4:0]  b_max_in,
    output logic        mask_valid_out,
    output logic        mask_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [19:0] count_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        frame_drop_out
`ifdef CENTROID_BBOX_EN
    ,
    output logic [10:0] bbox_xmin_out,
    output logic [10:0] bbox_xmax_out,
    output logic [9:0]  bbox_ymin_out,
    output logic [9:0]  bbox_ymax_out
`endif
);

    localparam logic [10:0]      H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]       V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

    tracker_state_t r_state;

    logic              r_mask_valid;
    logic              r_mask;
    logic [10:0]       r_hcount;
    logic [9:0]        r_vcount;

    logic [SUMX_W-1:0] r_sum_x;
    logic [SUMY_W-1:0] r_sum_y;
    logic [CNT_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_op_x;
    logic [DIV_W-1:0]  r_op_y;
    logic [CNT_W-1:0]  r_op_cnt;
    logic              r_start;

    logic [10:0]       r_x;
    logic [9:0]        r_y;
    logic [CNT_W-1:0]  r_count;
    logic              r_found;
    logic              r_valid;
    logic              r_drop;

    rgb565_t           w_pix;
    logic              w_mask;
    logic              w_eof;
    logic [SUMX_W-1:0] w_sum_x_nxt;
    logic [SUMY_W-1:0] w_sum_y_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DIV_W-1:0]  w_divisor;
    logic [DIV_W-1:0]  w_quo_x;
    logic [DIV_W-1:0]  w_quo_y;
    logic              w_done_x;
    logic              w_done_y;
    logic              w_unused_quo;

    assign w_pix  = rgb565_t'(pixel_data_in);
    assign w_mask = data_valid_in && pixel_masked(w_pix, r_min_in, g_max_in, b_max_in);
    assign w_eof  = data_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);

    // Next accumulator values include the current pixel, so the EOF pixel is counted.
    assign w_sum_x_nxt = r_sum_x + (w_mask ? SUMX_W'(hcount_in) : '0);
    assign w_sum_y_nxt = r_sum_y + (w_mask ? SUMY_W'(vcount_in) : '0);
    assign w_cnt_nxt   = r_cnt + (w_mask ? CNT_W'(1) : '0);
    assign w_divisor   = DIV_W'(r_op_cnt);

    // Quotients never exceed the active area, so only the low bits are reported.
    assign w_unused_quo = ^{w_quo_x[DIV_W-1:11], w_quo_y[DIV_W-1:10]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mask_valid <= 1'b0;
            r_mask       <= 1'b0;
            r_hcount     <= '0;
            r_vcount     <= '0;
        end else begin
            r_mask_valid <= data_valid_in;
            r_mask       <= w_mask;
            r_hcount     <= hcount_in;
            r_vcount     <= vcount_in;
        end
    end

`ifdef CENTROID_BBOX_EN
    logic [10:0] r_xmin, r_xmax, r_op_xmin, r_op_xmax, r_bb_xmin, r_bb_xmax;
    logic [9:0]  r_ymin, r_ymax, r_op_ymin, r_op_ymax, r_bb_ymin, r_bb_ymax;
    logic [10:0] w_xmin_nxt, w_xmax_nxt;
    logic [9:0]  w_ymin_nxt, w_ymax_nxt;

    assign w_xmin_nxt = (w_mask && hcount_in < r_xmin) ? hcount_in : r_xmin;
    assign w_xmax_nxt = (w_mask && hcount_in > r_xmax) ? hcount_in : r_xmax;
    assign w_ymin_nxt = (w_mask && vcount_in < r_ymin) ? vcount_in : r_ymin;
    assign w_ymax_nxt = (w_mask && vcount_in > r_ymax) ? vcount_in : r_ymax;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_xmin    <= '1;
            r_xmax    <= '0;
            r_ymin    <= '1;
            r_ymax    <= '0;
            r_op_xmin <= '0;
            r_op_xmax <= '0;
            r_op_ymin <= '0;
            r_op_ymax <= '0;
            r_bb_xmin <= '0;
            r_bb_xmax <= '0;
            r_bb_ymin <= '0;
            r_bb_ymax <= '0;
        end else begin
            if (w_eof) begin
                r_xmin <= '1;
                r_xmax <= '0;
                r_ymin <= '1;
                r_ymax <= '0;
                if (r_state == IDLE) begin
                    r_op_xmin <= w_xmin_nxt;
                    r_op_xmax <= w_xmax_nxt;
                    r_op_ymin <= w_ymin_nxt;
                    r_op_ymax <= w_ymax_nxt;
                end
            end else begin
                r_xmin <= w_xmin_nxt;
                r_xmax <= w_xmax_nxt;
                r_ymin <= w_ymin_nxt;
                r_ymax <= w_ymax_nxt;
            end
            if (r_state == DONE) begin
                // An empty frame reports a zero box rather than the reset sentinels.
                r_bb_xmin <= (r_op_cnt == '0) ? '0 : r_op_xmin;
                r_bb_xmax <= (r_op_cnt == '0) ? '0 : r_op_xmax;
                r_bb_ymin <= (r_op_cnt == '0) ? '0 : r_op_ymin;
                r_bb_ymax <= (r_op_cnt == '0) ? '0 : r_op_ymax;
            end
        end
    end

    assign bbox_xmin_out = r_bb_xmin;
    assign bbox_xmax_out = r_bb_xmax;
    assign bbox_ymin_out = r_bb_ymin;
    assign bbox_ymax_out = r_bb_ymax;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= IDLE;
            r_sum_x  <= '0;
            r_sum_y  <= '0;
            r_cnt    <= '0;
            r_op_x   <= '0;
            r_op_y   <= '0;
            r_op_cnt <= '0;
            r_start  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_count  <= '0;
            r_found  <= 1'b0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;

            if (w_eof) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_cnt   <= '0;
                if (r_state == IDLE) begin
                    r_op_x   <= DIV_W'(w_sum_x_nxt);
                    r_op_y   <= DIV_W'(w_sum_y_nxt);
                    r_op_cnt <= w_cnt_nxt;
                    r_start  <= 1'b1;
                    r_state  <= DIVIDE;
                end else begin
                    r_drop <= 1'b1;
                end
            end else begin
                r_sum_x <= w_sum_x_nxt;
                r_sum_y <= w_sum_y_nxt;
                r_cnt   <= w_cnt_nxt;
            end

            unique case (r_state)
                IDLE: ;
                DIVIDE: begin
                    if (w_done_x && w_done_y) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_x     <= w_quo_x[10:0];
                    r_y     <= w_quo_y[9:0];
                    r_count <= r_op_cnt;
                    r_found <= (r_op_cnt >= MIN_CNT);
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    divider_serial #(
        .WIDTH(DIV_W)
    ) u_div_x (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (r_start),
        .dividend_in (r_op_x),
        .divisor_in  (w_divisor),
        .quotient_out(w_quo_x),
        .done_out    (w_done_x)
    );

    divider_serial #(
        .WIDTH(DIV_W)
    ) u_div_y (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (r_start),
        .dividend_in (r_op_y),
        .divisor_in  (w_divisor),
        .quotient_out(w_quo_y),
        .done_out    (w_done_y)
    );

    assign mask_valid_out = r_mask_valid;
    assign mask_out       = r_mask;
    assign hcount_out     = r_hcount;
    assign vcount_out     = r_vcount;
    assign x_out          = r_x;
    assign y_out          = r_y;
    assign count_out      = r_count;
    assign found_out      = r_found;
    assign valid_out      = r_valid;
    assign frame_drop_out = r_drop;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: a full-size instance driven with sparse frames
// (only masked pixels plus the frame-end pixel) and an 8x4 instance for the frame-drop case.
module tb_centroid_tracker;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [19:0] cnt;
        logic        found;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        dv;
    logic [15:0] pixel;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [4:0]  rmin;
    logic [5:0]  gmax;
    logic [4:0]  bmax;

    logic        mask_valid_out, mask_out, found_out, valid_out, frame_drop_out;
    logic [10:0] hcount_out, x_out;
    logic [9:0]  vcount_out, y_out;
    logic [19:0] count_out;

    logic        s_dv;
    logic [15:0] s_pixel;
    logic [10:0] s_hc;
    logic [9:0]  s_vc;
    logic        s_mask_valid, s_mask, s_found, s_valid, s_drop;
    logic [10:0] s_hcount_out, s_x;
    logic [9:0]  s_vcount_out, s_y;
    logic [19:0] s_count;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   msx = 0, msy = 0, mcnt = 0;
    int   main_drops = 0, small_drops = 0;

    centroid_tracker u_dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .data_valid_in (dv),
        .pixel_data_in (pixel),
        .hcount_in     (hc),
        .vcount_in     (vc),
        .r_min_in      (rmin),
        .g_max_in      (gmax),
        .b_max_in      (bmax),
        .mask_valid_out(mask_valid_out),
        .mask_out      (mask_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .x_out         (x_out),
        .y_out         (y_out),
        .count_out     (count_out),
        .found_out     (found_out),
        .valid_out     (valid_out),
        .frame_drop_out(frame_drop_out)
    );

    centroid_tracker #(
        .H_ACTIVE (8),
        .V_ACTIVE (4),
        .MIN_COUNT(2)
    ) u_small (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .data_valid_in (s_dv),
        .pixel_data_in (s_pixel),
        .hcount_in     (s_hc),
        .vcount_in     (s_vc),
        .r_min_in      (rmin),
        .g_max_in      (gmax),
        .b_max_in      (bmax),
        .mask_valid_out(s_mask_valid),
        .mask_out      (s_mask),
        .hcount_out    (s_hcount_out),
        .vcount_out    (s_vcount_out),
        .x_out         (s_x),
        .y_out         (s_y),
        .count_out     (s_count),
        .found_out     (s_found),
        .valid_out     (s_valid),
        .frame_drop_out(s_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_drop_out) main_drops++;
        if (s_drop) small_drops++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit masked(input logic [15:0] p);
        return (p[15:11] >= rmin) && (p[10:5] <= gmax) && (p[4:0] <= bmax);
    endfunction

    // Drive one valid pixel, update the reference moments, return after it is sampled.
    task automatic pix(input logic [15:0] p, input int h, input int v);
        dv    = 1'b1;
        pixel = p;
        hc    = 11'(h);
        vc    = 10'(v);
        if (masked(p)) begin
            msx  += h;
            msy  += v;
            mcnt += 1;
        end
        @(negedge clk);
    endtask

    // Frame-end pixel (black) plus the expected report for this frame.
    task automatic eof();
        exp_t e;
        pix(16'h0000, 1023, 767);
        e.cnt   = 20'(mcnt);
        e.found = (mcnt >= 16);
        if (mcnt == 0) begin
            e.x = '0;
            e.y = '0;
        end else begin
            e.x = 11'(msx / mcnt);
            e.y = 10'(msy / mcnt);
        end
        sb.push_back(e);
        msx  = 0;
        msy  = 0;
        mcnt = 0;
    endtask

    // Called right after eof(): counts cycles past the EOF edge until valid_out.
    task automatic wait_result(input string tag);
        exp_t e;
        int   lat;
        dv  = 1'b0;
        lat = 0;
        while (!valid_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(valid_out ? lat : 999), 32'd34);
        e = sb.pop_front();
        check({tag, "_x"}, 32'(x_out), 32'(e.x));
        check({tag, "_y"}, 32'(y_out), 32'(e.y));
        check({tag, "_count"}, 32'(count_out), 32'(e.cnt));
        check({tag, "_found"}, 32'(found_out), 32'(e.found));
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        int nvalid;
        int seen_at;
        logic [10:0] cx;
        logic [9:0]  cy;
        logic [19:0] cc;
        logic        cf;

        rst_n = 1'b1;
        dv = 1'b0; pixel = '0; hc = '0; vc = '0;
        s_dv = 1'b0; s_pixel = '0; s_hc = '0; s_vc = '0;
        rmin = 5'd16; gmax = 6'd8; bmax = 5'd8;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_found", 32'(found_out), 32'd0);
        check("rst_mask_valid", 32'(mask_valid_out), 32'd0);
        check("rst_hcount", 32'(hcount_out), 32'd0);
        check("rst_drop", 32'(frame_drop_out), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single masked pixel.
        pix(16'hF800, 100, 50);
        eof();
        wait_result("single");

        // 5x5 red block centred at (600,400).
        for (int v = 398; v <= 402; v++)
            for (int h = 598; h <= 602; h++)
                pix(16'hF800, h, v);
        eof();
        wait_result("block");

        // Empty frame.
        pix(16'h0000, 5, 5);
        pix(16'h0000, 6, 5);
        eof();
        wait_result("black");

        // Mask stream timing; a non-qualified cycle must give mask 0.
        pix(16'hF800, 10, 3);
        check("stream_mv0", 32'(mask_valid_out), 32'd1);
        check("stream_m0", 32'(mask_out), 32'd1);
        check("stream_h0", 32'(hcount_out), 32'd10);
        check("stream_v0", 32'(vcount_out), 32'd3);
        pix(16'h07E0, 11, 3);
        check("stream_m1", 32'(mask_out), 32'd0);
        check("stream_h1", 32'(hcount_out), 32'd11);
        dv = 1'b0;
        pixel = 16'hF800;
        hc = 11'd12;
        @(negedge clk);
        check("stream_mv2", 32'(mask_valid_out), 32'd0);
        check("stream_m2", 32'(mask_out), 32'd0);
        check("stream_h2", 32'(hcount_out), 32'd12);
        eof();
        wait_result("stream");

        // Exactly MIN_COUNT pixels with a fractional mean, then one fewer.
        for (int h = 300; h <= 315; h++) pix(16'hF800, h, 200);
        eof();
        wait_result("min16");
        for (int h = 300; h <= 314; h++) pix(16'hF800, h, 200);
        eof();
        wait_result("min15");

        // Reset in the middle of a division.
        pix(16'hF800, 100, 50);
        eof();
        dv = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x", 32'(x_out), 32'd0);
        check("mid_rst_y", 32'(y_out), 32'd0);
        check("mid_rst_count", 32'(count_out), 32'd0);
        check("mid_rst_found", 32'(found_out), 32'd0);
        check("mid_rst_hcount", 32'(hcount_out), 32'd0);
        check("mid_rst_vcount", 32'(vcount_out), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) nvalid++;
        end
        check("mid_rst_no_valid", 32'(nvalid), 32'd0);
        pix(16'hF800, 7, 9);
        pix(16'hF800, 9, 11);
        eof();
        wait_result("after_rst");

        // 8x4 instance: full frame, second EOF 20 cycles later must be dropped.
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 8; h++) begin
                s_dv    = 1'b1;
                s_pixel = ((h == 2 && v == 1) || (h == 4 && v == 1) || (h == 3 && v == 3))
                          ? 16'hF800 : 16'h0000;
                s_hc    = 11'(h);
                s_vc    = 10'(v);
                @(negedge clk);
            end
        end
        seen_at = -1;
        cx = '0; cy = '0; cc = '0; cf = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 19) begin
                s_dv    = 1'b1;
                s_pixel = 16'hF800;
                s_hc    = 11'd7;
                s_vc    = 10'd3;
            end else begin
                s_dv = 1'b0;
            end
            if (i == 20) check("small_drop_pulse", 32'(s_drop), 32'd1);
            if (s_valid && seen_at < 0) begin
                seen_at = i;
                cx = s_x; cy = s_y; cc = s_count; cf = s_found;
            end
            @(negedge clk);
        end
        check("small_latency", 32'(seen_at), 32'd34);
        check("small_x", 32'(cx), 32'd3);
        check("small_y", 32'(cy), 32'd1);
        check("small_count", 32'(cc), 32'd3);
        check("small_found", 32'(cf), 32'd1);
        check("small_drop_total", 32'(small_drops), 32'd1);
        check("main_drop_total", 32'(main_drops), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
